// File: rtl/seq_compare_pkg.sv
// Shared types and constants for the sequential comparator.
package seq_compare_pkg;

  localparam int unsigned FLAGS_W = 6;

  // Bit positions inside the packed relation word {lt, le, gt, ge, eq, ne}.
  localparam int unsigned FLAG_LT = 5;
  localparam int unsigned FLAG_LE = 4;
  localparam int unsigned FLAG_GT = 3;
  localparam int unsigned FLAG_GE = 2;
  localparam int unsigned FLAG_EQ = 1;
  localparam int unsigned FLAG_NE = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    R_EQ,
    R_LT,
    R_GT
  } result_e;

  // Expand a resolved three-way result into the six relation flags.
  function automatic logic [FLAGS_W-1:0] flags_from_result(input result_e r);
    logic [FLAGS_W-1:0] f;
    logic lt;
    logic gt;
    logic eq;
    lt = (r == R_LT);
    gt = (r == R_GT);
    eq = (r == R_EQ);
    f          = '0;
    f[FLAG_LT] = lt;
    f[FLAG_LE] = lt | eq;
    f[FLAG_GT] = gt;
    f[FLAG_GE] = gt | eq;
    f[FLAG_EQ] = eq;
    f[FLAG_NE] = ~eq;
    return f;
  endfunction

endpackage

// File: rtl/seq_compare_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module compare_chunk
  import seq_compare_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output result_e          res_c_o
);

  // Three-way unsigned relation of the two slices.
  always_comb begin
    res_c_o = R_EQ;
    if (a_i < b_i) begin
      res_c_o = R_LT;
    end else if (a_i > b_i) begin
      res_c_o = R_GT;
    end
  end

endmodule

// File: rtl/seq_compare.sv
// Multi-cycle MSB-first magnitude/equality comparator with valid/ready handshakes.
module seq_compare
  import seq_compare_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FLAGS_W-1:0] flags
);

  localparam int unsigned N     = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  if (CHUNK == 0) begin : g_bad_chunk
    $error("seq_compare: CHUNK must be at least 1");
  end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("seq_compare: WIDTH must be a multiple of CHUNK");
  end

  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  result_e            res_q, res_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  result_e            chunk_res;
  result_e            res_step;

  // Operands shift left each RUN cycle, so the slice under test is always the top CHUNK bits.
  compare_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i     (a_q[WIDTH-1 -: CHUNK]),
    .b_i     (b_q[WIDTH-1 -: CHUNK]),
    .res_c_o (chunk_res)
  );

  // The first unequal slice decides; later slices cannot override it.
  assign res_step = (res_q == R_EQ) ? chunk_res : res_q;

  // State, operand and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= R_EQ;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, datapath update and output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    flags_d     = flags_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Flipping both sign bits turns a two's-complement compare into an unsigned one.
          a_d        = (a_signed && b_signed) ? (a ^ MSB_MASK) : a;
          b_d        = (a_signed && b_signed) ? (b ^ MSB_MASK) : b;
          idx_d      = IDX_W'(N - 1);
          res_d      = R_EQ;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        res_d = res_step;
        a_d   = a_q << CHUNK;
        b_d   = b_q << CHUNK;
        if (idx_q == '0) begin
          flags_d     = flags_from_result(res_step);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign flags     = flags_q;

endmodule
